// File: rtl/qa_cci_host_emulator_if.sv
// CCI-S link bundle between the FPGA-side driver (master) and the host emulator (slave).
// Tx*: driver requests; Rx*/AlmFull/InitDn/SoftReset_n: host side; err_overflow: sticky drop flags.
interface qa_cci_host_emulator_if #(
  parameter int CCI_DATA_WIDTH   = 512,
  parameter int CCI_RX_HDR_WIDTH = 18,
  parameter int CCI_TX_HDR_WIDTH = 61
);
  logic [CCI_TX_HDR_WIDTH-1:0] ffs_vl61_LP32ui_sy2lp_C0TxHdr;
  logic                        ffs_vl_LP32ui_sy2lp_C0TxRdValid;
  logic [CCI_TX_HDR_WIDTH-1:0] ffs_vl61_LP32ui_sy2lp_C1TxHdr;
  logic [CCI_DATA_WIDTH-1:0]   ffs_vl512_LP32ui_sy2lp_C1TxData;
  logic                        ffs_vl_LP32ui_sy2lp_C1TxWrValid;
  logic                        ffs_vl_LP32ui_sy2lp_C1TxIrValid;

  logic                        ffs_vl_LP32ui_lp2sy_C0TxAlmFull;
  logic                        ffs_vl_LP32ui_lp2sy_C1TxAlmFull;
  logic [CCI_RX_HDR_WIDTH-1:0] ffs_vl18_LP32ui_lp2sy_C0RxHdr;
  logic [CCI_DATA_WIDTH-1:0]   ffs_vl512_LP32ui_lp2sy_C0RxData;
  logic                        ffs_vl_LP32ui_lp2sy_C0RxRdValid;
  logic                        ffs_vl_LP32ui_lp2sy_C0RxWrValid;
  logic                        ffs_vl_LP32ui_lp2sy_C0RxCgValid;
  logic                        ffs_vl_LP32ui_lp2sy_C0RxUgValid;
  logic                        ffs_vl_LP32ui_lp2sy_C0RxIrValid;
  logic [CCI_RX_HDR_WIDTH-1:0] ffs_vl18_LP32ui_lp2sy_C1RxHdr;
  logic                        ffs_vl_LP32ui_lp2sy_C1RxWrValid;
  logic                        ffs_vl_LP32ui_lp2sy_C1RxIrValid;
  logic                        ffs_vl_LP32ui_lp2sy_InitDnForSys;
  logic                        ffs_vl_LP32ui_lp2sy_SoftReset_n;
  logic [1:0]                  err_overflow;

  modport master (
    output ffs_vl61_LP32ui_sy2lp_C0TxHdr,
    output ffs_vl_LP32ui_sy2lp_C0TxRdValid,
    output ffs_vl61_LP32ui_sy2lp_C1TxHdr,
    output ffs_vl512_LP32ui_sy2lp_C1TxData,
    output ffs_vl_LP32ui_sy2lp_C1TxWrValid,
    output ffs_vl_LP32ui_sy2lp_C1TxIrValid,
    input  ffs_vl_LP32ui_lp2sy_C0TxAlmFull,
    input  ffs_vl_LP32ui_lp2sy_C1TxAlmFull,
    input  ffs_vl18_LP32ui_lp2sy_C0RxHdr,
    input  ffs_vl512_LP32ui_lp2sy_C0RxData,
    input  ffs_vl_LP32ui_lp2sy_C0RxRdValid,
    input  ffs_vl_LP32ui_lp2sy_C0RxWrValid,
    input  ffs_vl_LP32ui_lp2sy_C0RxCgValid,
    input  ffs_vl_LP32ui_lp2sy_C0RxUgValid,
    input  ffs_vl_LP32ui_lp2sy_C0RxIrValid,
    input  ffs_vl18_LP32ui_lp2sy_C1RxHdr,
    input  ffs_vl_LP32ui_lp2sy_C1RxWrValid,
    input  ffs_vl_LP32ui_lp2sy_C1RxIrValid,
    input  ffs_vl_LP32ui_lp2sy_InitDnForSys,
    input  ffs_vl_LP32ui_lp2sy_SoftReset_n,
    input  err_overflow
  );

  modport slave (
    input  ffs_vl61_LP32ui_sy2lp_C0TxHdr,
    input  ffs_vl_LP32ui_sy2lp_C0TxRdValid,
    input  ffs_vl61_LP32ui_sy2lp_C1TxHdr,
    input  ffs_vl512_LP32ui_sy2lp_C1TxData,
    input  ffs_vl_LP32ui_sy2lp_C1TxWrValid,
    input  ffs_vl_LP32ui_sy2lp_C1TxIrValid,
    output ffs_vl_LP32ui_lp2sy_C0TxAlmFull,
    output ffs_vl_LP32ui_lp2sy_C1TxAlmFull,
    output ffs_vl18_LP32ui_lp2sy_C0RxHdr,
    output ffs_vl512_LP32ui_lp2sy_C0RxData,
    output ffs_vl_LP32ui_lp2sy_C0RxRdValid,
    output ffs_vl_LP32ui_lp2sy_C0RxWrValid,
    output ffs_vl_LP32ui_lp2sy_C0RxCgValid,
    output ffs_vl_LP32ui_lp2sy_C0RxUgValid,
    output ffs_vl_LP32ui_lp2sy_C0RxIrValid,
    output ffs_vl18_LP32ui_lp2sy_C1RxHdr,
    output ffs_vl_LP32ui_lp2sy_C1RxWrValid,
    output ffs_vl_LP32ui_lp2sy_C1RxIrValid,
    output ffs_vl_LP32ui_lp2sy_InitDnForSys,
    output ffs_vl_LP32ui_lp2sy_SoftReset_n,
    output err_overflow
  );
endinterface

// File: rtl/qa_cci_host_emulator.sv
// CCI-S host emulator: C0 reads / C1 writes against a small line memory, tagged responses.
// Ports: clk, reset (async, active-high), cci (slave side of qa_cci_host_emulator_if).
module qa_cci_host_emulator #(
  parameter int CCI_DATA_WIDTH   = 512,
  parameter int CCI_RX_HDR_WIDTH = 18,
  parameter int CCI_TX_HDR_WIDTH = 61,
  parameter int CCI_TAG_WIDTH    = 13,
  parameter int MEM_LINES_LOG2   = 6,
  parameter int READ_LATENCY     = 4,
  parameter int REQ_FIFO_LOG2    = 3,
  parameter int ALMFULL_MARGIN   = 4,
  parameter int INIT_CYCLES      = 16
) (
  input logic clk,
  input logic reset,
  qa_cci_host_emulator_if.slave cci
);
  localparam int DW     = CCI_DATA_WIDTH;
  localparam int RW     = CCI_RX_HDR_WIDTH;
  localparam int XW     = CCI_TX_HDR_WIDTH;
  localparam int TW     = CCI_TAG_WIDTH;
  localparam int IW     = MEM_LINES_LOG2;
  localparam int PW     = REQ_FIFO_LOG2;
  localparam int CW     = REQ_FIFO_LOG2 + 1;
  localparam int DEPTH  = 1 << REQ_FIFO_LOG2;
  localparam int AF_LVL = DEPTH - ALMFULL_MARGIN;
  localparam int ICW    = $clog2(INIT_CYCLES + 1);
  localparam int A_LSB  = 14;
  localparam int RL     = READ_LATENCY;
  localparam logic [3:0] RSP_RD = 4'h4;
  localparam logic [3:0] RSP_WR = 4'h1;

  // ---------------- init sequencing ----------------
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t         state_q, state_d;
  logic [ICW-1:0] icnt_q, icnt_d;
  logic           init_dn;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      icnt_q  <= icnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    icnt_d  = icnt_q;
    unique case (state_q)
      ST_INIT: begin
        icnt_d = icnt_q + ICW'(1);
        if (icnt_q == ICW'(INIT_CYCLES - 1))
          state_d = ST_RUN;
      end
      ST_RUN: state_d = ST_RUN;
    endcase
  end

  assign init_dn = (state_q == ST_RUN);

  // ---------------- request decode ----------------
  logic [TW-1:0] rq_tag, wq_tag;
  logic [IW-1:0] rq_idx, wq_idx;
  logic          unused_bits;

  assign rq_tag = cci.ffs_vl61_LP32ui_sy2lp_C0TxHdr[TW-1:0];
  assign rq_idx = cci.ffs_vl61_LP32ui_sy2lp_C0TxHdr[A_LSB +: IW];
  assign wq_tag = cci.ffs_vl61_LP32ui_sy2lp_C1TxHdr[TW-1:0];
  assign wq_idx = cci.ffs_vl61_LP32ui_sy2lp_C1TxHdr[A_LSB +: IW];

  // Address bits above the memory index alias; interrupts are not modelled.
  assign unused_bits = ^{cci.ffs_vl61_LP32ui_sy2lp_C0TxHdr[XW-1:A_LSB+IW],
                         cci.ffs_vl61_LP32ui_sy2lp_C0TxHdr[A_LSB-1:TW],
                         cci.ffs_vl61_LP32ui_sy2lp_C1TxHdr[XW-1:A_LSB+IW],
                         cci.ffs_vl61_LP32ui_sy2lp_C1TxHdr[A_LSB-1:TW],
                         cci.ffs_vl_LP32ui_sy2lp_C1TxIrValid};

  // ---------------- read request FIFO ----------------
  logic [TW-1:0] rf_tag_q [DEPTH];
  logic [IW-1:0] rf_idx_q [DEPTH];
  logic [PW-1:0] rf_wp_q, rf_rp_q;
  logic [CW-1:0] rf_cnt_q, rf_cnt_d;
  logic          rf_full, rf_empty;
  logic          rf_push, rf_pop, rf_ovf;

  assign rf_empty = (rf_cnt_q == '0);
  assign rf_full  = (rf_cnt_q == CW'(DEPTH));
  assign rf_pop   = init_dn && !rf_empty;
  // A pop frees the slot in the same cycle, so push-on-full with pop is legal.
  assign rf_push  = cci.ffs_vl_LP32ui_sy2lp_C0TxRdValid && (!rf_full || rf_pop);
  assign rf_ovf   = cci.ffs_vl_LP32ui_sy2lp_C0TxRdValid && rf_full && !rf_pop;
  assign rf_cnt_d = rf_cnt_q + CW'(rf_push) - CW'(rf_pop);

  always_ff @(posedge clk) begin
    if (rf_push) begin
      rf_tag_q[rf_wp_q] <= rq_tag;
      rf_idx_q[rf_wp_q] <= rq_idx;
    end
  end

  // ---------------- write request FIFO ----------------
  logic [TW-1:0] wf_tag_q [DEPTH];
  logic [IW-1:0] wf_idx_q [DEPTH];
  logic [DW-1:0] wf_dat_q [DEPTH];
  logic [PW-1:0] wf_wp_q, wf_rp_q;
  logic [CW-1:0] wf_cnt_q, wf_cnt_d;
  logic          wf_full, wf_empty;
  logic          wf_push, wf_pop, wf_ovf;

  assign wf_empty = (wf_cnt_q == '0);
  assign wf_full  = (wf_cnt_q == CW'(DEPTH));
  assign wf_pop   = init_dn && !wf_empty;
  assign wf_push  = cci.ffs_vl_LP32ui_sy2lp_C1TxWrValid && (!wf_full || wf_pop);
  assign wf_ovf   = cci.ffs_vl_LP32ui_sy2lp_C1TxWrValid && wf_full && !wf_pop;
  assign wf_cnt_d = wf_cnt_q + CW'(wf_push) - CW'(wf_pop);

  always_ff @(posedge clk) begin
    if (wf_push) begin
      wf_tag_q[wf_wp_q] <= wq_tag;
      wf_idx_q[wf_wp_q] <= wq_idx;
      wf_dat_q[wf_wp_q] <= cci.ffs_vl512_LP32ui_sy2lp_C1TxData;
    end
  end

  // ---------------- FIFO control, flow control, errors ----------------
  logic       c0_af_q, c1_af_q;
  logic [1:0] err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_wp_q  <= '0;
      rf_rp_q  <= '0;
      rf_cnt_q <= '0;
      wf_wp_q  <= '0;
      wf_rp_q  <= '0;
      wf_cnt_q <= '0;
      c0_af_q  <= 1'b0;
      c1_af_q  <= 1'b0;
      err_q    <= '0;
    end else begin
      if (rf_push) rf_wp_q <= rf_wp_q + PW'(1);
      if (rf_pop)  rf_rp_q <= rf_rp_q + PW'(1);
      if (wf_push) wf_wp_q <= wf_wp_q + PW'(1);
      if (wf_pop)  wf_rp_q <= wf_rp_q + PW'(1);
      rf_cnt_q <= rf_cnt_d;
      wf_cnt_q <= wf_cnt_d;
      c0_af_q  <= (rf_cnt_d >= CW'(AF_LVL));
      c1_af_q  <= (wf_cnt_d >= CW'(AF_LVL));
      err_q    <= err_q | {wf_ovf, rf_ovf};
    end
  end

  // ---------------- line memory ----------------
  logic [DW-1:0] mem_q [1 << IW];
  logic [DW-1:0] rd_line;

  // Combinational read sampled in the pop cycle: a write popped in the
  // same cycle lands at the edge, so the read sees the old line.
  assign rd_line = mem_q[rf_idx_q[rf_rp_q]];

  always_ff @(posedge clk) begin
    if (wf_pop)
      mem_q[wf_idx_q[wf_rp_q]] <= wf_dat_q[wf_rp_q];
  end

  // ---------------- read response pipe ----------------
  logic [RL-1:0] rp_vld_q;
  logic [TW-1:0] rp_tag_q [RL];
  logic [DW-1:0] rp_dat_q [RL];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rp_vld_q <= '0;
      for (int i = 0; i < RL; i++) begin
        rp_tag_q[i] <= '0;
        rp_dat_q[i] <= '0;
      end
    end else begin
      rp_vld_q[0] <= rf_pop;
      rp_tag_q[0] <= rf_pop ? rf_tag_q[rf_rp_q] : '0;
      rp_dat_q[0] <= rf_pop ? rd_line : '0;
      for (int i = 1; i < RL; i++) begin
        rp_vld_q[i] <= rp_vld_q[i-1];
        rp_tag_q[i] <= rp_tag_q[i-1];
        rp_dat_q[i] <= rp_dat_q[i-1];
      end
    end
  end

  // ---------------- write response ----------------
  logic          wr_vld_q;
  logic [TW-1:0] wr_tag_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_vld_q <= 1'b0;
      wr_tag_q <= '0;
    end else begin
      wr_vld_q <= wf_pop;
      wr_tag_q <= wf_pop ? wf_tag_q[wf_rp_q] : '0;
    end
  end

  // ---------------- outputs ----------------
  assign cci.ffs_vl_LP32ui_lp2sy_C0TxAlmFull = c0_af_q;
  assign cci.ffs_vl_LP32ui_lp2sy_C1TxAlmFull = c1_af_q;

  assign cci.ffs_vl_LP32ui_lp2sy_C0RxRdValid = rp_vld_q[RL-1];
  assign cci.ffs_vl18_LP32ui_lp2sy_C0RxHdr   =
    rp_vld_q[RL-1] ? RW'({RSP_RD, 1'b0, rp_tag_q[RL-1]}) : '0;
  assign cci.ffs_vl512_LP32ui_lp2sy_C0RxData = rp_dat_q[RL-1];

  assign cci.ffs_vl_LP32ui_lp2sy_C1RxWrValid = wr_vld_q;
  assign cci.ffs_vl18_LP32ui_lp2sy_C1RxHdr   =
    wr_vld_q ? RW'({RSP_WR, 1'b0, wr_tag_q}) : '0;

  assign cci.ffs_vl_LP32ui_lp2sy_C0RxWrValid = 1'b0;
  assign cci.ffs_vl_LP32ui_lp2sy_C0RxCgValid = 1'b0;
  assign cci.ffs_vl_LP32ui_lp2sy_C0RxUgValid = 1'b0;
  assign cci.ffs_vl_LP32ui_lp2sy_C0RxIrValid = 1'b0;
  assign cci.ffs_vl_LP32ui_lp2sy_C1RxIrValid = 1'b0;

  assign cci.ffs_vl_LP32ui_lp2sy_InitDnForSys = init_dn;
  assign cci.ffs_vl_LP32ui_lp2sy_SoftReset_n  = init_dn;
  assign cci.err_overflow                     = err_q;
endmodule

// File: tb/tb_qa_cci_host_emulator.sv
// Scoreboard bench for qa_cci_host_emulator: expected responses queued at
// stimulus time, popped and compared as the DUT returns them.
module tb_qa_cci_host_emulator;
  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  qa_cci_host_emulator_if #(
    .CCI_DATA_WIDTH  (512),
    .CCI_RX_HDR_WIDTH(18),
    .CCI_TX_HDR_WIDTH(61)
  ) cci ();

  qa_cci_host_emulator dut (
    .clk  (clk),
    .reset(reset),
    .cci  (cci)
  );

  typedef struct {
    logic [17:0]  hdr;
    logic [511:0] dat;
    int           cyc;
  } rsp_t;

  rsp_t         rdq[$];
  rsp_t         wrq[$];
  logic [511:0] mdl [64];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           t0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] rsp_hdr(input logic [3:0] typ,
                                          input logic [12:0] tag);
    return {typ, 1'b0, tag};
  endfunction

  // Response monitor, sampled on the falling edge.
  always @(negedge clk) begin
    rsp_t e;
    if (!reset) begin
      if (cci.ffs_vl_LP32ui_lp2sy_C0RxRdValid) begin
        if (rdq.size() == 0) begin
          check("rd_unexp", 1, 0);
        end else begin
          e = rdq.pop_front();
          check("rd_hdr", cci.ffs_vl18_LP32ui_lp2sy_C0RxHdr, e.hdr);
          check("rd_dat", cci.ffs_vl512_LP32ui_lp2sy_C0RxData, e.dat);
          check("rd_cyc", cyc, e.cyc);
        end
      end
      if (cci.ffs_vl_LP32ui_lp2sy_C1RxWrValid) begin
        if (wrq.size() == 0) begin
          check("wr_unexp", 1, 0);
        end else begin
          e = wrq.pop_front();
          check("wr_hdr", cci.ffs_vl18_LP32ui_lp2sy_C1RxHdr, e.hdr);
          check("wr_cyc", cyc, e.cyc);
        end
      end
      if (cci.ffs_vl_LP32ui_lp2sy_C0RxWrValid | cci.ffs_vl_LP32ui_lp2sy_C0RxCgValid |
          cci.ffs_vl_LP32ui_lp2sy_C0RxUgValid | cci.ffs_vl_LP32ui_lp2sy_C0RxIrValid |
          cci.ffs_vl_LP32ui_lp2sy_C1RxIrValid)
        check("tied0", 1, 0);
    end
  end

  // One request cycle; entered and left at #1 after a rising edge.
  // rd_cyc < 0 means the default post-init latency (push + 1 pop + 4).
  task automatic issue(input bit rd, input logic [31:0] ra, input logic [12:0] rt,
                       input bit wr, input logic [31:0] wa, input logic [12:0] wt,
                       input logic [511:0] wd, input int rd_cyc, input bit keep);
    rsp_t e;
    logic [60:0] h;
    if (rd) begin
      h = '0;
      h[12:0] = rt;
      h[45:14] = ra;
      cci.ffs_vl61_LP32ui_sy2lp_C0TxHdr = h;
      cci.ffs_vl_LP32ui_sy2lp_C0TxRdValid = 1'b1;
      if (keep) begin
        e.hdr = rsp_hdr(4'h4, rt);
        e.dat = mdl[ra[5:0]];
        e.cyc = (rd_cyc < 0) ? cyc + 5 : rd_cyc;
        rdq.push_back(e);
      end
    end
    if (wr) begin
      h = '0;
      h[12:0] = wt;
      h[45:14] = wa;
      cci.ffs_vl61_LP32ui_sy2lp_C1TxHdr = h;
      cci.ffs_vl512_LP32ui_sy2lp_C1TxData = wd;
      cci.ffs_vl_LP32ui_sy2lp_C1TxWrValid = 1'b1;
      e.hdr = rsp_hdr(4'h1, wt);
      e.dat = '0;
      e.cyc = cyc + 2;
      wrq.push_back(e);
      mdl[wa[5:0]] = wd;
    end
    @(posedge clk);
    #1;
    cci.ffs_vl_LP32ui_sy2lp_C0TxRdValid = 1'b0;
    cci.ffs_vl_LP32ui_sy2lp_C1TxWrValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((rdq.size() != 0 || wrq.size() != 0) && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", rdq.size() + wrq.size(), 0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    t0 = cyc;
  endtask

  // Watches 20 cycles after release: init/soft-reset rise time, no Rx traffic.
  task automatic watch_init();
    int first_i = -1;
    int first_s = -1;
    int nvld = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (first_i < 0 && cci.ffs_vl_LP32ui_lp2sy_InitDnForSys) first_i = cyc - t0;
      if (first_s < 0 && cci.ffs_vl_LP32ui_lp2sy_SoftReset_n) first_s = cyc - t0;
      if (cci.ffs_vl_LP32ui_lp2sy_C0RxRdValid || cci.ffs_vl_LP32ui_lp2sy_C1RxWrValid)
        nvld++;
    end
    check("init_cyc", first_i, 16);
    check("srst_cyc", first_s, 16);
    check("rx_idle", nvld, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [511:0] d_a;
    logic [511:0] d_b;
    int base;
    d_a = {16{32'hDEADBEEF}};
    d_b = {8{64'h0123_4567_89AB_CDEF}};
    cci.ffs_vl61_LP32ui_sy2lp_C0TxHdr = '0;
    cci.ffs_vl_LP32ui_sy2lp_C0TxRdValid = 1'b0;
    cci.ffs_vl61_LP32ui_sy2lp_C1TxHdr = '0;
    cci.ffs_vl512_LP32ui_sy2lp_C1TxData = '0;
    cci.ffs_vl_LP32ui_sy2lp_C1TxWrValid = 1'b0;
    cci.ffs_vl_LP32ui_sy2lp_C1TxIrValid = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", {cci.ffs_vl_LP32ui_lp2sy_C0RxRdValid,
                      cci.ffs_vl_LP32ui_lp2sy_C1RxWrValid}, 0);
    check("rst_af", {cci.ffs_vl_LP32ui_lp2sy_C0TxAlmFull,
                     cci.ffs_vl_LP32ui_lp2sy_C1TxAlmFull}, 0);
    check("rst_init", {cci.ffs_vl_LP32ui_lp2sy_InitDnForSys,
                       cci.ffs_vl_LP32ui_lp2sy_SoftReset_n}, 0);
    check("rst_err", cci.err_overflow, 0);
    check("rst_hdr", cci.ffs_vl18_LP32ui_lp2sy_C0RxHdr, 0);
    check("rst_dat", cci.ffs_vl512_LP32ui_lp2sy_C0RxData, 0);
    release_reset();
    watch_init();

    // Write then read line 5; interrupt request toggled alongside.
    cci.ffs_vl_LP32ui_sy2lp_C1TxIrValid = 1'b1;
    issue(0, 0, 0, 1, 32'h5, 13'h0A3, d_a, -1, 1);
    issue(1, 32'h5, 13'h1FFF, 0, 0, 0, '0, -1, 1);
    cci.ffs_vl_LP32ui_sy2lp_C1TxIrValid = 1'b0;
    wait_idle();

    // Aliased address: 0x45 and 0x05 share a line.
    issue(0, 0, 0, 1, 32'h45, 13'h0101, d_b, -1, 1);
    issue(1, 32'h05, 13'h0102, 0, 0, 0, '0, -1, 1);
    wait_idle();

    // Same-cycle read and write to line 3: read sees the old line.
    issue(0, 0, 0, 1, 32'h3, 13'h0030, 512'h11, -1, 1);
    wait_idle();
    issue(1, 32'h3, 13'h0031, 1, 32'h3, 13'h0032, 512'h22, -1, 1);
    issue(1, 32'h3, 13'h0033, 0, 0, 0, '0, -1, 1);
    wait_idle();

    // Burst of reads before init: fill, almost-full, overflow drop.
    reset = 1'b1;
    release_reset();
    for (int i = 0; i < 9; i++) begin
      issue(1, (i % 2) ? 32'h5 : 32'h3, 13'(16'h0200 + i), 0, 0, 0, '0,
            t0 + 20 + i, i < 8);
      check("c0_af", cci.ffs_vl_LP32ui_lp2sy_C0TxAlmFull, ((i + 1) >= 4) ? 1 : 0);
      check("c1_af", cci.ffs_vl_LP32ui_lp2sy_C1TxAlmFull, 0);
      check("ovf", cci.err_overflow, (i == 8) ? 2'b01 : 2'b00);
    end
    wait_idle();
    check("ovf_sticky", cci.err_overflow, 2'b01);

    // Reset with reads in flight: nothing comes out, flags cleared.
    base = 16'h0300;
    for (int i = 0; i < 3; i++)
      issue(1, 32'h5, 13'(base + i), 0, 0, 0, '0, -1, 1);
    reset = 1'b1;
    rdq.delete();
    wrq.delete();
    #1;
    check("rst_flush", cci.ffs_vl_LP32ui_lp2sy_C0RxRdValid, 0);
    release_reset();
    check("ovf_clr", cci.err_overflow, 0);
    watch_init();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/qa_cci_host_emulator.md
Name: qa_cci_host_emulator

Overview:
- System-side responder for the CCI-S interface: accepts C0 read and C1 write requests from the FPGA-side driver, backs them with a small on-chip line memory, and returns CCI responses with tags echoed.
- Drives flow control, init-done and soft reset.
- Used as the host end of the link in simulation and in loopback bring-up builds, in place of the QPI system layer.

Parameters:
CCI_DATA_WIDTH, 512, cache-line data width
CCI_RX_HDR_WIDTH, 18, response header width
CCI_TX_HDR_WIDTH, 61, request header width
CCI_TAG_WIDTH, 13, mdata tag width
MEM_LINES_LOG2, 6, log2 of backing memory depth in lines
READ_LATENCY, 4, cycles from read-request pop to C0RxRdValid (>=1)
REQ_FIFO_LOG2, 3, log2 of each request FIFO depth
ALMFULL_MARGIN, 4, free entries remaining at which AlmFull asserts
INIT_CYCLES, 16, cycles after reset release before init done

Ports:
clk  in  1  clock; all logic rising-edge
reset  in  1  asynchronous, active-high reset
ffs_vl61_LP32ui_sy2lp_C0TxHdr  in  61  read request header
ffs_vl_LP32ui_sy2lp_C0TxRdValid  in  1  read request valid
ffs_vl61_LP32ui_sy2lp_C1TxHdr  in  61  write request header
ffs_vl512_LP32ui_sy2lp_C1TxData  in  512  write data
ffs_vl_LP32ui_sy2lp_C1TxWrValid  in  1  write request valid
ffs_vl_LP32ui_sy2lp_C1TxIrValid  in  1  interrupt request; ignored
ffs_vl_LP32ui_lp2sy_C0TxAlmFull  out  1  read FIFO almost full
ffs_vl_LP32ui_lp2sy_C1TxAlmFull  out  1  write FIFO almost full
ffs_vl18_LP32ui_lp2sy_C0RxHdr  out  18  read response header
ffs_vl512_LP32ui_lp2sy_C0RxData  out  512  read response data
ffs_vl_LP32ui_lp2sy_C0RxRdValid  out  1  read response valid
ffs_vl_LP32ui_lp2sy_C0RxWrValid/CgValid/UgValid/IrValid  out  1 each  tied 0
ffs_vl18_LP32ui_lp2sy_C1RxHdr  out  18  write response header
ffs_vl_LP32ui_lp2sy_C1RxWrValid  out  1  write response valid
ffs_vl_LP32ui_lp2sy_C1RxIrValid  out  1  tied 0
ffs_vl_LP32ui_lp2sy_InitDnForSys  out  1  system ready
ffs_vl_LP32ui_lp2sy_SoftReset_n  out  1  soft reset to driver, active low
err_overflow  out  2  sticky; bit0 read FIFO overflow, bit1 write FIFO overflow

Behaviour:
- Reset (async assert): all valids 0, AlmFull 0, InitDn 0, SoftReset_n 0, err_overflow 0, FIFOs and read pipe emptied, headers/data 0. Memory contents not reset.
- Init: counter starts on the first clk after reset release; InitDn and SoftReset_n go 1 together exactly INIT_CYCLES clocks after release and stay 1 until reset.
- Request header fields: Tx[CCI_TAG_WIDTH-1:0] = mdata tag; Tx[45:14] = line address. Memory index = address[MEM_LINES_LOG2-1:0]; upper bits ignored (aliasing wraps).
- Response header: Rx[12:0] = echoed tag; Rx[13] = 0; Rx[17:14] = type (4'h4 read, 4'h1 write).
- Capture: a valid request is pushed every cycle it is asserted, regardless of AlmFull or InitDn. Push when FIFO is full: request dropped, matching err_overflow bit set, sticky until reset.
- AlmFull: registered; 1 when occupancy >= 2^REQ_FIFO_LOG2 - ALMFULL_MARGIN after the current cycle's push/pop. The margin covers the driver's two registered hops.
- Pop: each FIFO pops at most one entry per cycle, only when InitDn = 1 and non-empty. Read and write FIFOs are independent.
- Read path: on pop, memory is read and tag/data enter a fixed shift pipe. C0RxRdValid asserts exactly READ_LATENCY cycles after the pop cycle. Back-to-back pops give back-to-back responses in request order.
- Write path: on pop, memory is written. C1RxWrValid with echoed tag asserts on the next cycle.
- Same-cycle read and write pop to the same index: the read returns the old data (read-before-write).
- A write popped before a read to the same index is visible to that read.
- Simultaneous push and pop on a full FIFO is not an overflow; occupancy is unchanged.
- C1TxIrValid has no effect.

Test Plan:
- Reset release, no traffic -> InitDn and SoftReset_n go 1 at exactly cycle 16; all Rx valids stay 0.
- Write addr 0x5 tag 0x0A3 data 0xDEAD..BEEF, then read addr 0x5 tag 0x1FFF -> C1RxWrValid hdr 0x040A3 one cycle after pop; C0RxRdValid hdr 0x11FFF with matching data 4 cycles after read pop.
- Write addr 0x45 with MEM_LINES_LOG2=6, read addr 0x05 -> same data returned (alias wrap).
- Before InitDn, push 8 reads -> C0TxAlmFull = 1 from 4 occupied; 9th push sets err_overflow[0] = 1 and is dropped; after InitDn exactly 8 responses return, tags in order.
- Same-cycle read and write pops to addr 0x3 (old 0x11, new 0x22) -> read returns 0x11; a subsequent read returns 0x22.
- Assert reset while 3 reads are in the pipe -> no further C0RxRdValid; err_overflow cleared; InitDn restarts the 16-cycle count.
